// File: rtl/cdb_arbiter_if.sv
// Producer-side result pushes and the shared broadcast bus of the CDB arbiter.
// master = producers/consumers side, slave = the arbiter itself.
interface cdb_arbiter_if #(
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
);
  logic                 alu_valid;
  logic [ROB_POS_W-1:0] alu_rob_pos;
  logic [DATA_W-1:0]    alu_val;
  logic                 alu_nxt_full;

  logic                 lsb_valid;
  logic [ROB_POS_W-1:0] lsb_rob_pos;
  logic [DATA_W-1:0]    lsb_val;
  logic                 lsb_nxt_full;

  logic                 cdb_valid;
  logic                 cdb_src;
  logic [ROB_POS_W-1:0] cdb_rob_pos;
  logic [DATA_W-1:0]    cdb_val;

  modport master (
    output alu_valid, alu_rob_pos, alu_val,
    output lsb_valid, lsb_rob_pos, lsb_val,
    input  alu_nxt_full, lsb_nxt_full,
    input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val
  );

  modport slave (
    input  alu_valid, alu_rob_pos, alu_val,
    input  lsb_valid, lsb_rob_pos, lsb_val,
    output alu_nxt_full, lsb_nxt_full,
    output cdb_valid, cdb_src, cdb_rob_pos, cdb_val
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two small result FIFOs (ALU, LSB) drained one entry
// per cycle onto a registered broadcast bus with round-robin on contention.
module cdb_arbiter #(
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy_i,
  input  logic       rollback_i,
  output logic       overflow_o,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic [DATA_W-1:0]    val;
  } entry_t;

  entry_t           mem_q [2][DEPTH];
  logic [PTR_W-1:0] head_q [2], head_d [2];
  logic [PTR_W-1:0] tail_q [2], tail_d [2];
  logic [CNT_W-1:0] cnt_q  [2], cnt_d  [2];

  logic   push_valid [2];
  entry_t push_entry [2];
  logic   push_acc   [2];
  logic   pop        [2];
  logic   nonempty   [2];
  logic   nxt_full   [2];

  logic   en;
  logic   grant_valid;
  logic   grant_lsb;
  src_e   grant_src;
  entry_t head_entry;

  src_e                 rr_q, rr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic                 cdb_src_q, cdb_src_d;
  logic [ROB_POS_W-1:0] cdb_rob_pos_q, cdb_rob_pos_d;
  logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;
  logic                 overflow_q, overflow_d;

  assign push_valid[0] = bus.alu_valid;
  assign push_valid[1] = bus.lsb_valid;
  assign push_entry[0] = '{rob_pos: bus.alu_rob_pos, val: bus.alu_val};
  assign push_entry[1] = '{rob_pos: bus.lsb_rob_pos, val: bus.lsb_val};

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    en = rdy_i && !rst && !rollback_i;

    for (int s = 0; s < 2; s++) nonempty[s] = (cnt_q[s] != '0);
    grant_valid = nonempty[0] || nonempty[1];
    if (nonempty[0] && nonempty[1]) grant_src = rr_q;
    else if (nonempty[1])           grant_src = SRC_LSB;
    else                            grant_src = SRC_ALU;
    grant_lsb  = (grant_src == SRC_LSB);
    head_entry = mem_q[grant_lsb][head_q[grant_lsb]];

    rr_d          = rr_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_src_d     = cdb_src_q;
    cdb_rob_pos_d = cdb_rob_pos_q;
    cdb_val_d     = cdb_val_q;
    overflow_d    = overflow_q;

    for (int s = 0; s < 2; s++) begin
      pop[s]      = en && grant_valid && (grant_lsb == (s == 1));
      // A full FIFO still accepts a push in the cycle it is being popped.
      push_acc[s] = en && push_valid[s] && ((cnt_q[s] != FULL_CNT) || pop[s]);
      if (en && push_valid[s] && (cnt_q[s] == FULL_CNT) && !pop[s]) overflow_d = 1'b1;
      head_d[s] = pop[s]      ? head_q[s] + PTR_W'(1) : head_q[s];
      tail_d[s] = push_acc[s] ? tail_q[s] + PTR_W'(1) : tail_q[s];
      cnt_d[s]  = cnt_q[s] + CNT_W'(push_acc[s]) - CNT_W'(pop[s]);
    end

    if (en) begin
      cdb_valid_d = grant_valid;
      if (grant_valid) begin
        cdb_src_d     = grant_lsb;
        cdb_rob_pos_d = head_entry.rob_pos;
        cdb_val_d     = head_entry.val;
        rr_d          = grant_lsb ? SRC_ALU : SRC_LSB;
      end
    end

    // Rollback wins over rdy gating: the speculative results are dead either way.
    if (rollback_i) begin
      for (int s = 0; s < 2; s++) begin
        head_d[s] = '0;
        tail_d[s] = '0;
        cnt_d[s]  = '0;
      end
      cdb_valid_d = 1'b0;
      rr_d        = SRC_ALU;
    end

    for (int s = 0; s < 2; s++) nxt_full[s] = !rst && (cnt_d[s] >= FULL_CNT);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '{default: '0};
      tail_q        <= '{default: '0};
      cnt_q         <= '{default: '0};
      rr_q          <= SRC_ALU;
      cdb_valid_q   <= 1'b0;
      cdb_src_q     <= 1'b0;
      cdb_rob_pos_q <= '0;
      cdb_val_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_src_q     <= cdb_src_d;
      cdb_rob_pos_q <= cdb_rob_pos_d;
      cdb_val_q     <= cdb_val_d;
      overflow_q    <= overflow_d;
    end
  end

  // NOTE: FIFO storage is not reset; the counts alone decide which slots hold live data.
  always_ff @(posedge clk) begin
    if (push_acc[0]) mem_q[0][tail_q[0]] <= push_entry[0];
    if (push_acc[1]) mem_q[1][tail_q[1]] <= push_entry[1];
  end

  assign bus.alu_nxt_full = nxt_full[0];
  assign bus.lsb_nxt_full = nxt_full[1];
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.cdb_rob_pos  = cdb_rob_pos_q;
  assign bus.cdb_val      = cdb_val_q;
  assign overflow_o       = overflow_q;
endmodule
